// File: rtl/l2_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// l2_rr_arbiter_if
//   Bundles the upstream per-port request buses, the single downstream L2
//   port and the grant status of the N-port round-robin L2 arbiter.
//
//   Parameters
//     N_PORTS : number of requesting ports
//     s_line  : cache line width in bits
//     IDX_W   : grant index width
//
//   Signals
//     req_read/req_write   [N_PORTS]          per-port line read/write request
//     req_address          [N_PORTS][32]      per-port line address
//     req_wdata            [N_PORTS][s_line]  per-port write line
//     req_resp             [N_PORTS]          one-hot completion to granted port
//     req_rdata            [s_line]           read line broadcast to all ports
//     l2_read/l2_write                        downstream command
//     l2_address [32], l2_wdata [s_line]      downstream address / write line
//     l2_resp, l2_rdata [s_line]              downstream completion / read line
//     grant_valid, grant_idx [IDX_W]          current owner of the L2 port
//
//   Modports
//     slave  : the arbiter's view
//     master : the view of the surrounding caches / L2 model
// ---------------------------------------------------------------------------
interface l2_rr_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int s_line  = 256,
  parameter int IDX_W   = $clog2(N_PORTS)
);
  logic [N_PORTS-1:0]             req_read;
  logic [N_PORTS-1:0]             req_write;
  logic [N_PORTS-1:0][31:0]       req_address;
  logic [N_PORTS-1:0][s_line-1:0] req_wdata;
  logic [N_PORTS-1:0]             req_resp;
  logic [s_line-1:0]              req_rdata;

  logic                           l2_read;
  logic                           l2_write;
  logic [31:0]                    l2_address;
  logic [s_line-1:0]              l2_wdata;
  logic                           l2_resp;
  logic [s_line-1:0]              l2_rdata;

  logic                           grant_valid;
  logic [IDX_W-1:0]               grant_idx;

  modport slave (
    input  req_read, req_write, req_address, req_wdata, l2_resp, l2_rdata,
    output req_resp, req_rdata, l2_read, l2_write, l2_address, l2_wdata,
           grant_valid, grant_idx
  );

  modport master (
    output req_read, req_write, req_address, req_wdata, l2_resp, l2_rdata,
    input  req_resp, req_rdata, l2_read, l2_write, l2_address, l2_wdata,
           grant_valid, grant_idx
  );
endinterface

// File: rtl/l2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// l2_rr_arbiter
//   N-port round-robin arbiter that multiplexes cache-line read/write requests
//   from N_PORTS upstream caches onto one L2/memory port. The grant is
//   registered; after each completed transaction priority rotates to the port
//   after the one just served, and a waiting port is handed the L2 port in the
//   very next cycle. A granted port that withdraws its request aborts the
//   transaction without rotating priority.
//
//   Ports
//     clk    : clock, all state on the rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : l2_rr_arbiter_if.slave (request buses, L2 port, grant status)
// ---------------------------------------------------------------------------
module l2_rr_arbiter #(
  parameter int N_PORTS  = 2,
  parameter int s_offset = 5,
  parameter int s_line   = 8 * 2**s_offset,
  parameter int IDX_W    = $clog2(N_PORTS)
) (
  input  logic           clk,
  input  logic           rst_n,
  l2_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;

  logic [N_PORTS-1:0] req_any;
  logic [N_PORTS-1:0] grant_onehot;
  logic [IDX_W-1:0]   ptr_after_grant;
  logic [IDX_W-1:0]   scan_start;
  logic [N_PORTS-1:0] scan_mask;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [s_line-1:0]  wdata_sel;

  // (base + k) mod N_PORTS, valid for any port count, not just powers of two
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned      k);
    int unsigned s;
    s = (32'(base) + k) % 32'(N_PORTS);
    return IDX_W'(s);
  endfunction

  assign req_any = bus.req_read | bus.req_write;

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
      assign grant_onehot[gi] = (grant_idx_reg == IDX_W'(gi));
      // Completion is steered combinationally so a one-cycle l2_resp gives a
      // one-cycle req_resp in the same cycle.
      assign bus.req_resp[gi] = (state_reg == BUSY) && grant_onehot[gi] && bus.l2_resp;
    end
  endgenerate

  assign ptr_after_grant = (grant_idx_reg == IDX_W'(N_PORTS - 1)) ? '0
                                                                  : grant_idx_reg + IDX_W'(1);

  // In BUSY the scan only matters on the completion cycle: it starts after the
  // finishing port and excludes it, so its still-high request is not re-granted.
  always_comb begin
    if (state_reg == BUSY) begin
      scan_start = ptr_after_grant;
      scan_mask  = req_any & ~grant_onehot;
    end else begin
      scan_start = rr_ptr_reg;
      scan_mask  = req_any;
    end
  end

  // Scan from the far end back to scan_start so the last hit written is the
  // nearest requester in rotation order.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (scan_mask[wrap_add(scan_start, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(scan_start, k);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      grant_idx_reg <= grant_idx_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    grant_idx_next = grant_idx_reg;
    rr_ptr_next    = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        // l2_resp in IDLE is deliberately not looked at
        if (sel_found) begin
          state_next     = BUSY;
          grant_idx_next = sel_idx;
        end
      end
      BUSY: begin
        if (bus.l2_resp) begin
          rr_ptr_next = ptr_after_grant;
          if (sel_found) begin
            grant_idx_next = sel_idx;
          end else begin
            state_next = IDLE;
          end
        end else if (!req_any[grant_idx_reg]) begin
          // withdrawn request: abort, priority stays where it was
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wdata_sel = bus.req_wdata[grant_idx_reg];

  // Output logic: downstream only ever sees the granted port while BUSY
  always_comb begin
    bus.l2_read    = 1'b0;
    bus.l2_write   = 1'b0;
    bus.l2_address = '0;
    bus.l2_wdata   = '0;
    bus.req_rdata  = bus.l2_rdata;
    if (state_reg == BUSY) begin
      bus.l2_read    = bus.req_read[grant_idx_reg];
      bus.l2_write   = bus.req_write[grant_idx_reg];
      bus.l2_address = bus.req_address[grant_idx_reg];
      bus.l2_wdata   = wdata_sel;
    end
  end

  assign bus.grant_valid = (state_reg == BUSY);
  assign bus.grant_idx   = grant_idx_reg;

endmodule

// File: doc/l2_rr_arbiter.md
# l2_rr_arbiter

- N-port round-robin arbiter multiplexing cache-line read/write requests from `N_PORTS` upstream caches onto a single L2/memory port.
- Generalises the two-port I/D arbiter to a parametrised port count:
  - registered grant;
  - fair rotation after each completed transaction;
  - zero-bubble hand-off between ports;
  - abort on request withdrawal.
- Sits between the L1 caches (and any later prefetch/victim ports) and the L2 cache.

## Interface

Parameters:
- `N_PORTS`, 2: number of requesting ports (≥2).
- `s_offset`, 5: log2 line bytes.
- `s_line`, 8*2**s_offset: line width in bits.
- `IDX_W`, $clog2(N_PORTS): grant index width.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_read`  in  [N_PORTS]  per-port line read request.
- `req_write`  in  [N_PORTS]  per-port line write request.
- `req_address`  in  [N_PORTS][32]  per-port line address.
- `req_wdata`  in  [N_PORTS][s_line]  per-port write line.
- `req_resp`  out  [N_PORTS]  one-hot completion pulse to the granted port.
- `req_rdata`  out  s_line  read line, broadcast; valid only with `req_resp`.
- `l2_read`  out  1  downstream read.
- `l2_write`  out  1  downstream write.
- `l2_address`  out  32  downstream address.
- `l2_wdata`  out  s_line  downstream write data.
- `l2_resp`  in  1  downstream completion.
- `l2_rdata`  in  s_line  downstream read data.
- `grant_valid`  out  1  a port currently owns the L2 port.
- `grant_idx`  out  IDX_W  owning port index.

## Operation

- Port p requests when `req_read[p] | req_write[p]`. Port p must hold read/write, address and wdata stable until `req_resp[p]`. A port never asserts read and write together.
- State:
  - FSM {IDLE, BUSY};
  - `grant_idx` register;
  - `rr_ptr` register (highest-priority port).
- Selection: first requesting port found scanning `rr_ptr`, `rr_ptr+1`, … mod `N_PORTS`.
- IDLE:
  - Any request → BUSY, `grant_idx` = selected port.
  - Otherwise stay IDLE.
  - No downstream signals are driven from IDLE (no combinational pass-through).
- BUSY, granted port g:
  - `l2_read/l2_write/l2_address/l2_wdata` = port g's inputs.
  - `req_resp[g]` = `l2_resp`; all other `req_resp` bits 0.
  - `req_rdata` = `l2_rdata`.
- On `l2_resp` in BUSY:
  - `rr_ptr` ← (g+1) mod `N_PORTS`.
  - Port g's request in that same cycle is ignored.
  - If any other port requests: stay BUSY, `grant_idx` ← first requester scanning from g+1, excluding g.
  - Otherwise → IDLE.
- Abort: in BUSY, if port g deasserts both read and write without `l2_resp`:
  - → IDLE next edge;
  - `rr_ptr` unchanged;
  - downstream read/write follow port g combinationally, so they drop that same cycle.
- Outputs when not BUSY:
  - `l2_read`, `l2_write` = 0;
  - `l2_address` = 0;
  - `l2_wdata` = 0;
  - `req_resp` = 0;
  - `req_rdata` = `l2_rdata`.

## Timing

- Reset (`rst_n` low, asynchronous):
  - state IDLE, `grant_idx` = 0, `rr_ptr` = 0;
  - `grant_valid` = 0;
  - all `l2_*` outputs and `req_resp` = 0.
- Reset mid-transaction:
  - the in-flight grant is dropped immediately and no `req_resp` is issued;
  - after release, resumes IDLE with port 0 highest priority.
- Request latency: request first seen in cycle t (IDLE) → `grant_valid` and `l2_read`/`l2_write` asserted in cycle t+1.
- Hand-off: `l2_resp` for port g in cycle t, another port requesting → new port's request on `l2_*` in cycle t+1 (no idle bubble).
- `req_resp[g]` is combinational from `l2_resp`, same cycle. A single-cycle `l2_resp` yields a single-cycle `req_resp`.
- Simultaneous requests: resolved purely by `rr_ptr` order.
- Starvation bound: a continuously requesting port is granted within `N_PORTS-1` completed transactions.
- `l2_resp` while IDLE is ignored (no `req_resp`, no state change).

## Test plan

- **Reset defaults:** `N_PORTS`=4, assert `rst_n`=0 mid-BUSY → same-cycle `l2_read`=0, `req_resp`=0, `grant_valid`=0. After release, a request from port 2 is granted with `grant_idx`=2 one cycle later.
- **Single port read:**
  - port 1 read of 0x0000_1040 at cycle 0 → `l2_read`=1 and `l2_address`=0x0000_1040 at cycle 1;
  - L2 returns `l2_resp` with data 0xA5… at cycle 4 → `req_resp`=4'b0010, `req_rdata`=0xA5… at cycle 4;
  - FSM back in IDLE at cycle 5.
- **Round-robin fairness:** all 4 ports hold requests continuously, L2 responds every 3 cycles → grant order 0,1,2,3,0. `l2_*` is never idle between transactions.
- **Zero-bubble hand-off:** port 0 writes, port 3 waiting → the cycle after port 0's `l2_resp`, `l2_read`/`l2_write` and `l2_address` reflect port 3's request. Port 0's still-high request on the resp cycle is not re-granted.
- **Abort:** port 2 granted, drops its read two cycles later without resp:
  - `l2_read`=0 that cycle;
  - FSM IDLE next cycle;
  - `rr_ptr` unchanged, so port 2 wins the next simultaneous contest against port 3.
- **Stray resp:** `l2_resp`=1 while IDLE → all `req_resp`=0, state unchanged.
